// File: rtl/cplx_div_pkg.sv
// Shared defaults, derived widths and FSM states for the complex divider.
// Build option: CPLX_DIV_ROUND_EN adds a rounding iteration (half away from zero).
package cplx_div_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int FRAC_W_DEF = 8;

`ifdef CPLX_DIV_ROUND_EN
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    function automatic int prod_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic int den_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic int iter_n(input int data_w);
        return data_w + ROUND_BITS;
    endfunction

    localparam int PROD_W_DEF = prod_w(DATA_W_DEF);
    localparam int DEN_W_DEF  = den_w(DATA_W_DEF);
    localparam int ITER_DEF   = iter_n(DATA_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cplx_div_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// The caller guarantees the quotient fits in ITER bits.
module seq_udiv
    import cplx_div_pkg::*;
#(
    parameter int XW   = PROD_W_DEF + FRAC_W_DEF + ROUND_BITS,
    parameter int DW   = DEN_W_DEF,
    parameter int ITER = ITER_DEF,
    parameter int RW   = PROD_W_DEF + FRAC_W_DEF + ITER_DEF + 1
) (
    input  logic            clk_i,
    input  logic            load,
    input  logic            step,
    input  logic [XW-1:0]   dividend,
    input  logic [DW-1:0]   divisor,
    output logic [ITER-1:0] quo
);

    logic [RW-1:0]   rem_p2;
    logic [RW-1:0]   dsh_p2;
    logic [ITER-1:0] quo_p2;
    logic            ge;

    assign ge  = (rem_p2 >= dsh_p2);
    assign quo = quo_p2;

    // iteration stage: divisor starts aligned to the top quotient bit and walks right
    always_ff @(posedge clk_i) begin
        if (load) begin
            rem_p2 <= RW'(dividend);
            dsh_p2 <= RW'(divisor) << (ITER - 1);
            quo_p2 <= '0;
        end else if (step) begin
            if (ge) begin
                rem_p2 <= rem_p2 - dsh_p2;
            end
            dsh_p2 <= dsh_p2 >> 1;
            quo_p2 <= {quo_p2[ITER-2:0], ge};
        end
    end

endmodule

// File: rtl/cplx_div.sv
// Complex divider a/b with FRAC_W fractional quotient bits, serial per-channel division.
// Build option: CPLX_DIV_ROUND_EN (round half away from zero, one extra cycle).
module cplx_div
    import cplx_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic signed [DATA_W-1:0] data_a_i_i,
    input  logic signed [DATA_W-1:0] data_a_q_i,
    input  logic signed [DATA_W-1:0] data_b_i_i,
    input  logic signed [DATA_W-1:0] data_b_q_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic signed [DATA_W-1:0] data_i_o,
    output logic signed [DATA_W-1:0] data_q_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     div_zero_o
);

    localparam int PW   = prod_w(DATA_W);
    localparam int DW   = den_w(DATA_W);
    localparam int ITER = iter_n(DATA_W);
    localparam int XW   = PW + FRAC_W + ROUND_BITS;
    localparam int RW   = PW + FRAC_W + ITER + 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, state_nxt;
    logic [CW-1:0] cnt_p1;

    logic signed [DATA_W-1:0] a_i_p0, a_q_p0, b_i_p0, b_q_p0;
    logic signed [PW-1:0]     ni_p0, nq_p0;
    logic signed [DW-1:0]     den_p0;
    logic [PW-1:0]            mag_i_p0, mag_q_p0;

    logic          neg_i_p1, neg_q_p1, ovf_i_p1, ovf_q_p1, dz_p1;
    logic          load, step, fin;
    logic [ITER-1:0] quo_i, quo_q;

    function automatic logic [PW-1:0] abs_p(input logic signed [PW-1:0] v);
        return v[PW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Quotient fits only if |N|*2^F < D*2^(DATA_W-1); anything larger clamps.
    function automatic logic ovf_chk(input logic [PW-1:0] mag, input logic [DW-1:0] den);
        return (RW'(mag) << FRAC_W) >= (RW'(den) << (DATA_W - 1));
    endfunction

    function automatic logic signed [DATA_W-1:0] finish_q(input logic [ITER-1:0] q,
                                                          input logic neg,
                                                          input logic ovf,
                                                          input logic dz);
        logic [DATA_W:0]        mag;
        logic signed [DATA_W:0] sval;
`ifdef CPLX_DIV_ROUND_EN
        mag = (DATA_W+1)'(({1'b0, q} + 1'b1) >> 1);
`else
        mag = (DATA_W+1)'(q);
`endif
        if (dz) begin
            return '0;
        end
        if (ovf || mag[DATA_W] || mag[DATA_W-1]) begin
            return neg ? Q_MIN : Q_MAX;
        end
        sval = neg ? -$signed(mag) : $signed(mag);
        return sval[DATA_W-1:0];
    endfunction

    assign ready_o = (state == ST_IDLE);
    assign valid_o = (state == ST_DONE);
    assign load    = (state == ST_PREP);
    assign step    = (state == ST_DIV) && (cnt_p1 != CW'(ITER));
    assign fin     = (state == ST_DIV) && (cnt_p1 == CW'(ITER));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state  <= ST_IDLE;
            cnt_p1 <= '0;
        end else begin
            state  <= state_nxt;
            cnt_p1 <= (state == ST_DIV) ? cnt_p1 + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (valid_i) state_nxt = ST_PREP;
            ST_PREP: state_nxt = ST_DIV;
            ST_DIV:  if (fin) state_nxt = ST_DONE;
            ST_DONE: if (ready_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // operand capture stage
    always_ff @(posedge clk_i) begin
        if (ready_o && valid_i) begin
            a_i_p0 <= data_a_i_i;
            a_q_p0 <= data_a_q_i;
            b_i_p0 <= data_b_i_i;
            b_q_p0 <= data_b_q_i;
        end
    end

    assign ni_p0    = PW'(a_i_p0) * PW'(b_i_p0) + PW'(a_q_p0) * PW'(b_q_p0);
    assign nq_p0    = PW'(a_q_p0) * PW'(b_i_p0) - PW'(a_i_p0) * PW'(b_q_p0);
    assign den_p0   = DW'(b_i_p0) * DW'(b_i_p0) + DW'(b_q_p0) * DW'(b_q_p0);
    assign mag_i_p0 = abs_p(ni_p0);
    assign mag_q_p0 = abs_p(nq_p0);

    // PREP stage: signs and overflow decisions travel beside the dividers
    always_ff @(posedge clk_i) begin
        if (load) begin
            neg_i_p1 <= ni_p0[PW-1];
            neg_q_p1 <= nq_p0[PW-1];
            ovf_i_p1 <= ovf_chk(mag_i_p0, $unsigned(den_p0));
            ovf_q_p1 <= ovf_chk(mag_q_p0, $unsigned(den_p0));
            dz_p1    <= (den_p0 == '0);
        end
    end

    seq_udiv #(.XW(XW), .DW(DW), .ITER(ITER), .RW(RW)) u_div_i (
        .clk_i    (clk_i),
        .load     (load),
        .step     (step),
        .dividend (XW'(mag_i_p0) << (FRAC_W + ROUND_BITS)),
        .divisor  ($unsigned(den_p0)),
        .quo      (quo_i)
    );

    seq_udiv #(.XW(XW), .DW(DW), .ITER(ITER), .RW(RW)) u_div_q (
        .clk_i    (clk_i),
        .load     (load),
        .step     (step),
        .dividend (XW'(mag_q_p0) << (FRAC_W + ROUND_BITS)),
        .divisor  ($unsigned(den_p0)),
        .quo      (quo_q)
    );

    // result stage: sign, saturation and divide-by-zero applied after magnitude division
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_i_o   <= '0;
            data_q_o   <= '0;
            div_zero_o <= 1'b0;
        end else if (fin) begin
            data_i_o   <= finish_q(quo_i, neg_i_p1, ovf_i_p1, dz_p1);
            data_q_o   <= finish_q(quo_q, neg_q_p1, ovf_q_p1, dz_p1);
            div_zero_o <= dz_p1;
        end
    end

endmodule

// File: tb/tb_cplx_div.sv
// Directed bench for cplx_div at DATA_W=18, FRAC_W=8 (honours CPLX_DIV_ROUND_EN).
module tb_cplx_div;

    localparam int W = 18;
`ifdef CPLX_DIV_ROUND_EN
    localparam int LAT     = W + 3;
    localparam int EXP_NEG = -171;
`else
    localparam int LAT     = W + 2;
    localparam int EXP_NEG = -170;
`endif

    logic                clk_i = 1'b0;
    logic                arst_n_i = 1'b1;
    logic signed [W-1:0] data_a_i_i = '0, data_a_q_i = '0, data_b_i_i = '0, data_b_q_i = '0;
    logic                valid_i = 1'b0;
    logic                ready_o;
    logic signed [W-1:0] data_i_o, data_q_o;
    logic                valid_o;
    logic                ready_i = 1'b0;
    logic                div_zero_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cplx_div dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .data_a_i_i (data_a_i_i),
        .data_a_q_i (data_a_q_i),
        .data_b_i_i (data_b_i_i),
        .data_b_q_i (data_b_q_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i_o   (data_i_o),
        .data_q_o   (data_q_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .div_zero_o (div_zero_o)
    );

    task automatic do_op(input logic signed [W-1:0] ai, input logic signed [W-1:0] aq,
                         input logic signed [W-1:0] bi, input logic signed [W-1:0] bq,
                         output logic signed [W-1:0] oi, output logic signed [W-1:0] oq,
                         output logic odz, output int lat);
        @(negedge clk_i);
        data_a_i_i = ai; data_a_q_i = aq; data_b_i_i = bi; data_b_q_i = bq;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                lat = n;
                break;
            end
        end
        oi = data_i_o; oq = data_q_o; odz = div_zero_o;
    endtask

    task automatic consume();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 arst_n_i = 1'b0;
        #2;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (data_i_o !== 18'sd0 || data_q_o !== 18'sd0) begin errors++; $display("FAIL reset_data: got %0d,%0d expected 0,0", data_i_o, data_q_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    task automatic test_basic();
        logic signed [W-1:0] oi, oq; logic odz; int lat;
        do_op(256, 0, 256, 0, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (oi !== 18'sd256 || oq !== 18'sd0) begin errors++; $display("FAIL basic_value: got %0d,%0d expected 256,0", oi, oq); end
        checks++; if (odz !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b expected 0", odz); end
        consume();
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL basic_release: got ready %b valid %b expected 1 0", ready_o, valid_o); end
    endtask

    task automatic test_stall();
        logic signed [W-1:0] oi, oq; logic odz; int lat; logic seen;
        do_op(256, 0, 256, 0, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            valid_i = (c == 2);
            data_a_i_i = 1; data_a_q_i = 1; data_b_i_i = 1; data_b_q_i = 1;
            @(posedge clk_i);
            #1;
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_i_o !== 18'sd256 || data_q_o !== 18'sd0) begin
                errors++;
                $display("FAIL stall_hold: got valid %b ready %b data %0d,%0d expected 1 0 256,0", valid_o, ready_o, data_i_o, data_q_o);
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        consume();
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL stall_release: got ready %b valid %b expected 1 0", ready_o, valid_o); end
        seen = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stall_no_accept: got valid seen %b expected 0", seen); end
    endtask

    task automatic test_div_zero();
        logic signed [W-1:0] oi, oq; logic odz; int lat;
        do_op(100, -7, 0, 0, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL dz_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (oi !== 18'sd0 || oq !== 18'sd0) begin errors++; $display("FAIL dz_value: got %0d,%0d expected 0,0", oi, oq); end
        checks++; if (odz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", odz); end
        consume();
    endtask

    task automatic test_reset_midflight();
        logic signed [W-1:0] oi, oq; logic odz; int lat;
        @(negedge clk_i);
        data_a_i_i = 256; data_a_q_i = 0; data_b_i_i = 256; data_b_q_i = 0;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #2 arst_n_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ctrl: got valid %b ready %b expected 0 1", valid_o, ready_o); end
        checks++; if (div_zero_o !== 1'b0 || data_i_o !== 18'sd0) begin errors++; $display("FAIL midreset_out: got dz %b data %0d expected 0 0", div_zero_o, data_i_o); end
        @(negedge clk_i);
        arst_n_i = 1'b1;
        do_op(0, 512, 0, 256, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (oi !== 18'sd512 || oq !== 18'sd0 || odz !== 1'b0) begin errors++; $display("FAIL post_reset_value: got %0d,%0d dz %b expected 512,0 dz 0", oi, oq, odz); end
        consume();
    endtask

    task automatic test_negative();
        logic signed [W-1:0] oi, oq; logic odz; int lat;
        do_op(-2, 0, 3, 0, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (oi != EXP_NEG || oq !== 18'sd0) begin errors++; $display("FAIL neg_value: got %0d,%0d expected %0d,0", oi, oq, EXP_NEG); end
        consume();
    endtask

    task automatic test_saturation();
        logic signed [W-1:0] oi, oq; logic odz; int lat;
        do_op(131071, -131072, 1, 0, oi, oq, odz, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL sat_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (oi != 131071 || oq != -131072) begin errors++; $display("FAIL sat_value: got %0d,%0d expected 131071,-131072", oi, oq); end
        checks++; if (odz !== 1'b0) begin errors++; $display("FAIL sat_dz: got %b expected 0", odz); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_div_zero();
        test_reset_midflight();
        test_negative();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cplx_div.md
CPLX_DIV -- requirements
Module: cplx_div

Interface
REQ-001 SHALL have parameter DATA_W, default 18: width of the signed I/Q input and output samples.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of the quotient, so output = (a/b)*2^FRAC_W.
REQ-003 SHALL have port clk_i  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port arst_n_i  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports data_a_i_i, data_a_q_i  input  DATA_W signed: dividend a, I and Q parts.
REQ-006 SHALL have ports data_b_i_i, data_b_q_i  input  DATA_W signed: divisor b, I and Q parts.
REQ-007 SHALL have port valid_i  input  1: operands valid.
REQ-008 SHALL have port ready_o  output  1: block idle, can accept operands.
REQ-009 SHALL have ports data_i_o, data_q_o  output  DATA_W signed: quotient a/b, I and Q parts.
REQ-010 SHALL have port valid_o  output  1: quotient valid.
REQ-011 SHALL have port ready_i  input  1: downstream accepts the quotient.
REQ-012 SHALL have port div_zero_o  output  1: b was 0+0j; qualified by valid_o.

Function
REQ-013 SHALL accept operands only on a cycle with valid_i=1 and ready_o=1, and register all four operands on that edge.
REQ-014 SHALL compute N_i = a_i*b_i + a_q*b_q, N_q = a_q*b_i - a_i*b_q and D = b_i^2 + b_q^2 at full precision (2*DATA_W+1 bits), with no intermediate truncation.
REQ-015 SHALL output Q_x = (N_x*2^FRAC_W)/D, truncated toward zero, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-016 SHALL implement an FSM with states IDLE -> PREP (1 cycle, products, signs, magnitudes, overflow precheck) -> DIV (DATA_W cycles, one quotient bit per cycle per channel, restoring) -> DONE.
REQ-017 SHALL assert valid_o exactly DATA_W+2 cycles after the accepting edge (20 at default), regardless of operand values.
REQ-018 SHALL hold data_i_o, data_q_o, div_zero_o and valid_o stable in DONE until valid_o and ready_i are both 1, then return to IDLE on that edge.
REQ-019 SHALL drive ready_o=1 only in IDLE; no operand acceptance is possible in the handshake cycle of DONE (no overlap).
REQ-020 SHALL, when D==0, produce data_i_o=data_q_o=0 and div_zero_o=1, with the normal latency.
REQ-021 SHALL apply saturation independently per channel, decided from the PREP overflow precheck, and apply the sign after the magnitude division.
REQ-022 SHALL ignore valid_i outside IDLE and ignore ready_i while valid_o=0.

Reset
REQ-023 SHALL, on arst_n_i=0, immediately force state IDLE, ready_o=1 (combinational from state), valid_o=0, div_zero_o=0, data_i_o=data_q_o=0, independent of clk_i.
REQ-024 SHALL abandon any in-flight division on reset; the first accept after release starts a clean operation.

Configuration
REQ-025 SHALL support macro CPLX_DIV_ROUND_EN: when defined, one extra DIV iteration and round-half-away-from-zero (latency DATA_W+3); when undefined, truncation toward zero per REQ-015 (latency DATA_W+2).

Structure
REQ-026 SHALL place DATA_W/FRAC_W defaults, derived widths (product, denominator, iteration count incl. rounding bit) and the FSM state enum in package cplx_div_pkg.
REQ-027 SHALL implement the per-channel unsigned serial divider as sub-module seq_udiv, instantiated twice (I, Q) and sharing the divisor D.

Verification (DATA_W=18, FRAC_W=8)
REQ-028 SHALL check a=(256,0), b=(256,0) -> data_i_o=256, data_q_o=0, div_zero_o=0, valid_o 20 cycles after accept.
REQ-029 SHALL check a=(0,512), b=(0,256) -> (512,0); and a=(-2,0), b=(3,0) -> (-170,0) without macro, (-171,0) with CPLX_DIV_ROUND_EN.
REQ-030 SHALL check a=(100,-7), b=(0,0) -> (0,0), div_zero_o=1, valid_o at the normal latency.
REQ-031 SHALL check a=(131071,-131072), b=(1,0) -> data_i_o=131071, data_q_o=-131072 (saturated).
REQ-032 SHALL check ready_i held 0 for 5 cycles after valid_o -> outputs stable, ready_o=0, a valid_i pulse meanwhile is not accepted.
REQ-033 SHALL check arst_n_i pulsed low at cycle 7 of DIV -> valid_o=0, ready_o=1 before the next clock edge; the next operation returns correct results.
